// File: rtl/branch_predictor.sv
// branch_predictor
// Dynamic branch predictor with resolution tracking. The IF stage looks up the
// fetch PC in a direct-mapped BTB whose entries also carry a 2-bit saturating
// counter, and gets a predicted next PC with no added latency. The EX stage
// hands back the resolved outcome plus the prediction that travelled down the
// pipe; the block trains the table and raises a registered redirect on a
// mispredict.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   if_pc             fetch PC to predict
//   pred_hit          if_pc hits a valid BTB entry
//   pred_taken        predicted taken
//   pred_next_pc      predicted next fetch PC
//   ex_valid          EX holds a valid, non-stalled instruction
//   ex_is_branch      EX instruction is a conditional branch
//   ex_pc             PC of the EX instruction
//   ex_taken          resolved branch outcome
//   ex_target         resolved branch target
//   ex_pred_next_pc   prediction captured in IF for this instruction
//   redirect_valid    one-cycle pulse: flush IF/ID and load redirect_pc
//   redirect_pc       correct next PC while redirect_valid is high
//   branch_count      resolved branches seen (saturating)
//   mispred_count     mispredicts seen (saturating)

module branch_predictor #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_next_pc,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic [XLEN-1:0]  ex_pred_next_pc,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] tableValid_q;
    logic [TAG_W-1:0]   tableTag_q    [ENTRIES];
    logic [XLEN-1:0]    tableTarget_q [ENTRIES];
    logic [1:0]         tableCtr_q    [ENTRIES];

    logic             redirectValid_q, redirectValid_d;
    logic [XLEN-1:0]  redirectPc_q, redirectPc_d;
    logic [CNT_W-1:0] branchCount_q, branchCount_d;
    logic [CNT_W-1:0] mispredCount_q, mispredCount_d;

    logic [IDX_W-1:0] ifIdx, exIdx;
    logic [TAG_W-1:0] ifTag, exTag;
    logic             exHit;
    logic             resolve;
    logic             mispredict;
    logic [XLEN-1:0]  actualPc;
    logic [1:0]       exCtr_d;

    // Fetch-side lookup reads only registered table state, so a same-cycle
    // update to the same index is seen here one cycle later.
    always_comb begin
        ifIdx        = if_pc[IDX_W+1:2];
        ifTag        = if_pc[XLEN-1:IDX_W+2];
        pred_hit     = tableValid_q[ifIdx] && (tableTag_q[ifIdx] == ifTag);
        pred_taken   = pred_hit && tableCtr_q[ifIdx][1];
        pred_next_pc = pred_taken ? tableTarget_q[ifIdx] : (if_pc + XLEN'(4));
    end

    // Resolution side: work out the true next PC, compare it with what IF
    // fetched, and compute the trained counter value for a hitting entry.
    always_comb begin
        exIdx      = ex_pc[IDX_W+1:2];
        exTag      = ex_pc[XLEN-1:IDX_W+2];
        exHit      = tableValid_q[exIdx] && (tableTag_q[exIdx] == exTag);
        resolve    = ex_valid && ex_is_branch;
        actualPc   = ex_taken ? ex_target : (ex_pc + XLEN'(4));
        mispredict = (actualPc != ex_pred_next_pc);
        exCtr_d    = tableCtr_q[exIdx];
        if (ex_taken) begin
            if (tableCtr_q[exIdx] != 2'b11) begin
                exCtr_d = tableCtr_q[exIdx] + 2'd1;
            end
        end else begin
            if (tableCtr_q[exIdx] != 2'b00) begin
                exCtr_d = tableCtr_q[exIdx] - 2'd1;
            end
        end
    end

    // Next-state for the redirect pulse and the saturating statistics. The
    // redirect PC deliberately holds its last value when no redirect fires.
    always_comb begin
        redirectValid_d = resolve && mispredict;
        redirectPc_d    = (resolve && mispredict) ? actualPc : redirectPc_q;
        branchCount_d   = branchCount_q;
        mispredCount_d  = mispredCount_q;
        if (resolve && (branchCount_q != '1)) begin
            branchCount_d = branchCount_q + CNT_W'(1);
        end
        if (resolve && mispredict && (mispredCount_q != '1)) begin
            mispredCount_d = mispredCount_q + CNT_W'(1);
        end
    end

    // Table training. Reset invalidates every entry and parks every counter at
    // weakly-not-taken; tags and targets are left alone since an invalid entry
    // never matches. A not-taken miss leaves the table untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            tableValid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tableCtr_q[i] <= 2'b01;
            end
        end else if (resolve) begin
            if (exHit) begin
                tableCtr_q[exIdx] <= exCtr_d;
                if (ex_taken) begin
                    tableTarget_q[exIdx] <= ex_target;
                end
            end else if (ex_taken) begin
                tableValid_q[exIdx]  <= 1'b1;
                tableTag_q[exIdx]    <= exTag;
                tableTarget_q[exIdx] <= ex_target;
                tableCtr_q[exIdx]    <= 2'b10;
            end
        end
    end

    // Redirect and statistics registers; reset also drops a redirect that
    // would otherwise have been raised on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirectValid_q <= 1'b0;
            redirectPc_q    <= '0;
            branchCount_q   <= '0;
            mispredCount_q  <= '0;
        end else begin
            redirectValid_q <= redirectValid_d;
            redirectPc_q    <= redirectPc_d;
            branchCount_q   <= branchCount_d;
            mispredCount_q  <= mispredCount_d;
        end
    end

    assign redirect_valid = redirectValid_q;
    assign redirect_pc    = redirectPc_q;
    assign branch_count   = branchCount_q;
    assign mispred_count  = mispredCount_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
// Directed bench for branch_predictor. Stimulus steps push expected values,
// tagged with the cycle they must appear in, into a scoreboard queue; a
// separate monitor on the falling edge pops and compares them. Any redirect
// pulse the scoreboard did not ask for is also flagged.
// The statistics counters are narrowed to 3 bits so saturation is reachable.

module tb_branch_predictor;

    localparam int XLEN    = 64;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 3;

    logic             clk;
    logic             rst;
    logic [XLEN-1:0]  if_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_next_pc;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic [XLEN-1:0]  ex_pred_next_pc;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispred_count;

    typedef enum int {K_HIT, K_TAKEN, K_NEXT, K_RV, K_RPC, K_BCNT, K_MCNT} kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t        expQ[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          seenRv;
    logic [63:0] act;

    branch_predictor #(
        .XLEN(XLEN),
        .ENTRIES(ENTRIES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_pc(if_pc),
        .pred_hit(pred_hit),
        .pred_taken(pred_taken),
        .pred_next_pc(pred_next_pc),
        .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc),
        .ex_taken(ex_taken),
        .ex_target(ex_target),
        .ex_pred_next_pc(ex_pred_next_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .branch_count(branch_count),
        .mispred_count(mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp shared by stimulus (read just after the edge) and monitor.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every scoreboard entry due this cycle, report stale
    // entries, and flag redirect pulses nobody expected.
    always @(negedge clk) begin
        seenRv = 1'b0;
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].cyc <= cyc) begin
                case (expQ[i].kind)
                    K_HIT:   act = {63'd0, pred_hit};
                    K_TAKEN: act = {63'd0, pred_taken};
                    K_NEXT:  act = pred_next_pc;
                    K_RV:    act = {63'd0, redirect_valid};
                    K_RPC:   act = redirect_pc;
                    K_BCNT:  act = {61'd0, branch_count};
                    default: act = {61'd0, mispred_count};
                endcase
                total = total + 1;
                if (expQ[i].kind == K_RV) seenRv = 1'b1;
                if (expQ[i].cyc < cyc) begin
                    bad = bad + 1;
                    $display("[TB] FAIL %s: missed check cycle %0d (now %0d)",
                             expQ[i].name, expQ[i].cyc, cyc);
                end else if (act !== expQ[i].exp) begin
                    bad = bad + 1;
                    $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                             expQ[i].name, act, expQ[i].exp, cyc);
                end
                expQ.delete(i);
            end
        end
        if (redirect_valid === 1'b1 && !seenRv) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL unexpected_redirect: got 1 expected 0 (cycle %0d)", cyc);
        end
    end

    task automatic applyStimulus(input bit r, input logic [63:0] ifPc,
                                 input bit v, input bit br,
                                 input logic [63:0] exPc, input bit tk,
                                 input logic [63:0] tgt, input logic [63:0] prd);
        @(posedge clk);
        #1;
        rst             = r;
        if_pc           = ifPc;
        ex_valid        = v;
        ex_is_branch    = br;
        ex_pc           = exPc;
        ex_taken        = tk;
        ex_target       = tgt;
        ex_pred_next_pc = prd;
    endtask

    task automatic idle(input logic [63:0] ifPc);
        applyStimulus(1'b0, ifPc, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
    endtask

    // Offset 0: combinational outputs in the current cycle.
    // Offset 1: registered outputs after the coming clock edge.
    task automatic checkOutput(input kind_e k, input int offset,
                               input logic [63:0] val, input string nm);
        exp_t e;
        e.cyc  = cyc + offset;
        e.kind = k;
        e.exp  = val;
        e.name = nm;
        expQ.push_back(e);
    endtask

    task automatic checkPred(input bit hit, input bit tk,
                             input logic [63:0] nxt, input string nm);
        checkOutput(K_HIT, 0, {63'd0, hit}, {nm, "_hit"});
        checkOutput(K_TAKEN, 0, {63'd0, tk}, {nm, "_taken"});
        checkOutput(K_NEXT, 0, nxt, {nm, "_next"});
    endtask

    task automatic checkRegs(input bit rv, input logic [63:0] rpc,
                             input int bc, input int mc, input string nm);
        checkOutput(K_RV, 1, {63'd0, rv}, {nm, "_rv"});
        checkOutput(K_RPC, 1, rpc, {nm, "_rpc"});
        checkOutput(K_BCNT, 1, 64'(bc), {nm, "_bcnt"});
        checkOutput(K_MCNT, 1, 64'(mc), {nm, "_mcnt"});
    endtask

    initial begin
        rst             = 1'b1;
        if_pc           = '0;
        ex_valid        = 1'b0;
        ex_is_branch    = 1'b0;
        ex_pc           = '0;
        ex_taken        = 1'b0;
        ex_target       = '0;
        ex_pred_next_pc = '0;
        repeat (2) @(posedge clk);

        // Reset state and a cold miss.
        idle(64'h1000);
        checkPred(1'b0, 1'b0, 64'h1004, "reset_lookup");
        checkOutput(K_RV, 0, 64'd0, "reset_rv");
        checkOutput(K_RPC, 0, 64'd0, "reset_rpc");
        checkOutput(K_BCNT, 0, 64'd0, "reset_bcnt");
        checkOutput(K_MCNT, 0, 64'd0, "reset_mcnt");

        // Taken miss allocates the entry and redirects to the target.
        applyStimulus(1'b0, 64'h1000, 1'b1, 1'b1, 64'h1000, 1'b1, 64'h0F00, 64'h1004);
        checkPred(1'b0, 1'b0, 64'h1004, "alloc_pre");
        checkRegs(1'b1, 64'h0F00, 1, 1, "alloc");
        idle(64'h1000);
        checkPred(1'b1, 1'b1, 64'h0F00, "alloc_post");
        checkOutput(K_RV, 1, 64'd0, "pulse_end");

        // Two not-taken resolves: counter 10 -> 01 -> 00.
        applyStimulus(1'b0, 64'h1000, 1'b1, 1'b1, 64'h1000, 1'b0, 64'h0F00, 64'h0F00);
        checkRegs(1'b1, 64'h1004, 2, 2, "nt1");
        applyStimulus(1'b0, 64'h1000, 1'b1, 1'b1, 64'h1000, 1'b0, 64'h0F00, 64'h1004);
        checkPred(1'b1, 1'b0, 64'h1004, "nt1_post");
        checkRegs(1'b0, 64'h1004, 3, 2, "nt2");
        idle(64'h1000);
        checkPred(1'b1, 1'b0, 64'h1004, "nt2_post");

        // Aliasing: same index, different tag.
        idle(64'h1100);
        checkPred(1'b0, 1'b0, 64'h1104, "alias_miss");
        applyStimulus(1'b0, 64'h1000, 1'b1, 1'b1, 64'h1100, 1'b1, 64'h3000, 64'h1104);
        checkPred(1'b1, 1'b0, 64'h1004, "alias_pre");
        checkRegs(1'b1, 64'h3000, 4, 3, "alias");
        idle(64'h1000);
        checkPred(1'b0, 1'b0, 64'h1004, "alias_evicted");
        idle(64'h1100);
        checkPred(1'b1, 1'b1, 64'h3000, "alias_new");

        // Same-cycle lookup and training on one index.
        applyStimulus(1'b0, 64'h2000, 1'b1, 1'b1, 64'h2000, 1'b1, 64'h2400, 64'h2004);
        checkPred(1'b0, 1'b0, 64'h2004, "same_old");
        checkRegs(1'b1, 64'h2400, 5, 4, "same");
        // ex_valid=0 with a mismatching not-taken branch: ignored.
        applyStimulus(1'b0, 64'h2000, 1'b0, 1'b1, 64'h2000, 1'b0, 64'h2400, 64'h9990);
        checkPred(1'b1, 1'b1, 64'h2400, "same_new");
        checkRegs(1'b0, 64'h2400, 5, 4, "novalid");
        // ex_is_branch=0: ignored as well.
        applyStimulus(1'b0, 64'h2000, 1'b1, 1'b0, 64'h2000, 1'b0, 64'h2400, 64'h9990);
        checkRegs(1'b0, 64'h2400, 5, 4, "nobranch");
        idle(64'h2000);
        checkPred(1'b1, 1'b1, 64'h2400, "untrained");

        // Hit+taken retargets and saturates at 11; branch count saturates at 7.
        applyStimulus(1'b0, 64'h2000, 1'b1, 1'b1, 64'h2000, 1'b1, 64'h2800, 64'h2400);
        checkRegs(1'b1, 64'h2800, 6, 5, "retarget");
        applyStimulus(1'b0, 64'h2000, 1'b1, 1'b1, 64'h2000, 1'b1, 64'h2800, 64'h2800);
        checkPred(1'b1, 1'b1, 64'h2800, "retarget_post");
        checkRegs(1'b0, 64'h2800, 7, 5, "sat_ctr");
        applyStimulus(1'b0, 64'h2000, 1'b1, 1'b1, 64'h2000, 1'b0, 64'h2800, 64'h2800);
        checkRegs(1'b1, 64'h2004, 7, 6, "sat_cnt");
        idle(64'h2000);
        checkPred(1'b1, 1'b1, 64'h2800, "ctr_from_11");

        // Fall-through wraps at the top of the address space.
        idle(64'hFFFF_FFFF_FFFF_FFFC);
        checkPred(1'b0, 1'b0, 64'h0, "wrap");

        // Reset together with a mispredicting resolve: no redirect, no training.
        applyStimulus(1'b1, 64'h2000, 1'b1, 1'b1, 64'h5000, 1'b1, 64'h6000, 64'h5004);
        checkRegs(1'b0, 64'h0, 0, 0, "rst_mid");
        idle(64'h5000);
        checkPred(1'b0, 1'b0, 64'h5004, "rst_notrain");
        idle(64'h2000);
        checkPred(1'b0, 1'b0, 64'h2004, "rst_cleared");

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
